mm_timing_ctrl: RTL
===================

Name: mm_timing_ctrl

Overview:
Symbol-timing controller that sequences the fixed-point Mueller & Müller TED in the MSK demod chain. It divides the oversampled stream into symbol periods and issues one strobe per symbol to the TED. It accumulates returned TED errors and slips the symbol boundary by ±1 sample when the accumulated error crosses a threshold. It also reports lock status. It sits between the matched filter output and the TED/slicer.

Parameters:
SPS, 8, samples per symbol (≥4)
ERR_W, 16, TED error width (signed Q1.15)
ACC_W, 24, error accumulator width (signed)
SLIP_TH, 16384, accumulator magnitude that triggers a slip
LOCK_ERR, 2048, |err| below this counts as "good"
UNLOCK_ERR, 8192, |err| at or above this while LOCKED drops lock
LOCK_CNT, 64, consecutive good errors needed to declare lock
WARMUP, 2, TED outputs discarded after strobe start

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
en_i  in  1  enable; low forces IDLE
smp_valid_i  in  1  one oversampled sample present this cycle
sym_strobe_o  out  1  sample this cycle is the symbol sample, forwarded to TED
ted_err_i  in  ERR_W  signed TED error
ted_err_valid_i  in  1  ted_err_i valid
slip_o  out  2  01 = period shortened (advance), 10 = lengthened (retard), one-cycle pulse
locked_o  out  1  lock indicator
state_o  out  2  0 IDLE, 1 ACQUIRE, 2 TRACK, 3 LOCKED
slip_cnt_o  out  16  total slips since leaving IDLE, saturating

Behaviour:
- Reset: all outputs 0; state IDLE; counters and accumulator 0.
- States:
  - IDLE → ACQUIRE on en_i=1.
  - ACQUIRE → TRACK after WARMUP ted_err_valid_i pulses are discarded.
  - TRACK → LOCKED when the good-error run count reaches LOCK_CNT.
  - LOCKED → TRACK on |err| ≥ UNLOCK_ERR; the run count clears.
  - Any state → IDLE when en_i=0. Same cycle: counters and accumulator clear, no strobe issued.
- Sample counter cnt advances only on smp_valid_i. Current period length is len ∈ {SPS-1, SPS, SPS+1}.
- sym_strobe_o is combinational with smp_valid_i: it asserts when smp_valid_i=1 and cnt==len-1 in any non-IDLE state. On that cycle cnt→0 and len reloads from the pending slip (default SPS).
- Error accumulation (TRACK/LOCKED only):
  - On ted_err_valid_i: acc ← sat(acc + sext(err)).
  - If the new acc ≥ SLIP_TH: pending = retard, acc −= SLIP_TH.
  - If the new acc ≤ −SLIP_TH: pending = advance, acc += SLIP_TH.
  - Positive error means sampling early, so the period is lengthened.
- At most one pending slip. A further crossing before the next strobe is dropped, and acc is clamped to ±(SLIP_TH−1).
- slip_o pulses on the strobe cycle that loads len≠SPS. slip_cnt_o increments on that cycle and saturates at 0xFFFF.
- Simultaneous ted_err_valid_i and strobe: the error is applied first, so its slip affects the period starting at this strobe.
- Lock metric: |err| uses the magnitude of the most-negative value as 2^(ERR_W-1).
  - |err| < LOCK_ERR increments the run count (saturating at LOCK_CNT).
  - Otherwise the run count clears.
- locked_o = (state==LOCKED), registered.
- Latency: slip decision is registered 1 cycle after ted_err_valid_i. Strobe has zero latency relative to smp_valid_i.
- Reset mid-operation: immediate return to reset values. No strobe in the reset release cycle.

Decomposition:
- Package mm_timing_pkg: state enum (IDLE/ACQUIRE/TRACK/LOCKED), slip encoding constants, and a sat_add function for ACC_W.
- One natural sub-module, mm_lock_det: run-count and lock/unlock thresholds, exposing good/bad pulse inputs and a locked output.
- Strobe counter and accumulator stay in the top module.

Test Plan:
- Reset/enable: assert reset, en_i=1, smp_valid_i every cycle → all outputs 0. After release, sym_strobe_o on every 8th valid sample starting at the 8th, and state_o=1.
- Warmup: first 2 ted_err_valid_i with err=+20000 → no slip, state_o goes 1→2 after the second.
- Retard slip: in TRACK, one err=+16384 → slip_o=10 at the next strobe, following period 9 samples, then back to 8, and slip_cnt_o=1.
- Advance with stalls: err=−16384, smp_valid_i toggling 50% → slip_o=01, next period 7 valid samples (14 cycles).
- Lock/unlock:
  - 64 errors of +1000 → locked_o=1 one cycle after the 64th.
  - One err=−9000 → locked_o=0, state_o=2.
  - A 63-run then err=3000 → no lock.
- Saturation and en drop:
  - Two +16384 errors within one period → exactly one slip, acc=16383.
  - en_i=0 mid-period → state_o=0 next cycle and no strobes.
  - Re-enable → fresh 8-sample count.

Source files
------------

// File: rtl/mm_timing_pkg.sv
// Shared types and helpers for the Mueller & Muller symbol-timing controller.
// Holds the state encoding, the slip codes and the saturating accumulator add.
package mm_timing_pkg;

   localparam int ACC_W = 24;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_ACQUIRE = 2'd1,
      ST_TRACK   = 2'd2,
      ST_LOCKED  = 2'd3
   } state_t;

   localparam logic [1:0] SLIP_NONE = 2'b00;
   localparam logic [1:0] SLIP_ADV  = 2'b01;
   localparam logic [1:0] SLIP_RET  = 2'b10;

   function automatic logic signed [ACC_W-1:0] sat_add(
      input logic signed [ACC_W-1:0] a,
      input logic signed [ACC_W-1:0] b
   );
      logic [ACC_W:0] s;
      s = {a[ACC_W-1], a} + {b[ACC_W-1], b};
      if (s[ACC_W] != s[ACC_W-1])
         sat_add = s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
      else
         sat_add = s[ACC_W-1:0];
   endfunction

endpackage

// File: rtl/mm_lock_det.sv
// Lock detector: counts consecutive good TED errors and tracks the lock flag.
// o_locked_nxt lets the parent FSM change state on the same edge as o_locked.
module mm_lock_det
   import mm_timing_pkg::*;
#(
   parameter int LOCK_CNT = 64
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clr,
   input  logic i_good,
   input  logic i_miss,
   input  logic i_bad,
   output logic o_locked_nxt,
   output logic o_locked
);

   localparam int RUN_W = $clog2(LOCK_CNT + 1);

   logic [RUN_W-1:0] r_run;
   logic [RUN_W-1:0] w_run_nxt;
   logic             r_locked;
   logic             w_locked_nxt;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      w_run_nxt    = r_run;
      w_locked_nxt = r_locked;
      if (i_clr) begin
         w_run_nxt    = '0;
         w_locked_nxt = 1'b0;
      end else if (i_good) begin
         if (r_run != RUN_W'(LOCK_CNT))
            w_run_nxt = r_run + 1'b1;
         if (r_run >= RUN_W'(LOCK_CNT - 1))
            w_locked_nxt = 1'b1;
      end else if (i_miss) begin
         w_run_nxt = '0;
         if (i_bad)
            w_locked_nxt = 1'b0;
      end
   end

   // NOTE: state registers use non-blocking assignments only.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_run    <= '0;
         r_locked <= 1'b0;
      end else begin
         r_run    <= w_run_nxt;
         r_locked <= w_locked_nxt;
      end
   end

   assign o_locked_nxt = w_locked_nxt;
   assign o_locked     = r_locked;

endmodule

// File: rtl/mm_timing_ctrl.sv
// Symbol-timing controller: divides the oversampled stream into symbol periods,
// strobes the TED once per symbol and slips the boundary from accumulated error.
module mm_timing_ctrl
   import mm_timing_pkg::*;
#(
   parameter int SPS        = 8,
   parameter int ERR_W      = 16,
   parameter int SLIP_TH    = 16384,
   parameter int LOCK_ERR   = 2048,
   parameter int UNLOCK_ERR = 8192,
   parameter int LOCK_CNT   = 64,
   parameter int WARMUP     = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    en_i,
   input  logic                    smp_valid_i,
   output logic                    sym_strobe_o,
   input  logic signed [ERR_W-1:0] ted_err_i,
   input  logic                    ted_err_valid_i,
   output logic [1:0]              slip_o,
   output logic                    locked_o,
   output logic [1:0]              state_o,
   output logic [15:0]             slip_cnt_o
);

   localparam int CNT_W  = $clog2(SPS + 2);
   localparam int WARM_W = $clog2(WARMUP + 1);

   localparam logic signed [ACC_W-1:0] TH_POS    = ACC_W'(SLIP_TH);
   localparam logic signed [ACC_W-1:0] TH_NEG    = -TH_POS;
   localparam logic signed [ACC_W-1:0] CLAMP_POS = TH_POS - 1;
   localparam logic signed [ACC_W-1:0] CLAMP_NEG = -CLAMP_POS;
   localparam logic [ERR_W:0]          LOCK_M    = (ERR_W + 1)'(LOCK_ERR);
   localparam logic [ERR_W:0]          UNLOCK_M  = (ERR_W + 1)'(UNLOCK_ERR);

   state_t                  r_state;
   logic [WARM_W-1:0]       r_warm;
   logic [CNT_W-1:0]        r_cnt;
   logic [CNT_W-1:0]        r_len;
   logic signed [ACC_W-1:0] r_acc;
   logic [1:0]              r_pend;
   logic [15:0]             r_slip_cnt;

   logic                    w_tracking;
   logic                    w_err_act;
   logic signed [ACC_W-1:0] w_err_ext;
   logic signed [ACC_W-1:0] w_sum;
   logic signed [ACC_W-1:0] w_acc_nxt;
   logic [1:0]              w_pend_nxt;
   logic [CNT_W-1:0]        w_len_load;
   logic [ERR_W:0]          w_err_wide;
   logic [ERR_W:0]          w_mag;
   logic                    w_locked_nxt;
   logic                    w_locked;

   assign w_tracking = en_i && (r_state == ST_TRACK || r_state == ST_LOCKED);
   assign w_err_act  = w_tracking && ted_err_valid_i;
   assign w_err_ext  = ACC_W'(ted_err_i);
   assign w_sum      = sat_add(r_acc, w_err_ext);

   // Two's-complement magnitude one bit wider so the most-negative code maps to 2^(ERR_W-1).
   assign w_err_wide = {ted_err_i[ERR_W-1], ted_err_i};
   assign w_mag      = w_err_wide[ERR_W] ? (~w_err_wide + 1'b1) : w_err_wide;

   // The current error is folded in before the strobe consumes the pending slip,
   // so a crossing on a strobe cycle already shapes the period starting there.
   always_comb begin
      w_acc_nxt  = r_acc;
      w_pend_nxt = r_pend;
      if (w_err_act) begin
         w_acc_nxt = w_sum;
         if (w_sum >= TH_POS) begin
            if (r_pend == SLIP_NONE) begin
               w_pend_nxt = SLIP_RET;
               w_acc_nxt  = w_sum - TH_POS;
            end else begin
               w_acc_nxt  = CLAMP_POS;
            end
         end else if (w_sum <= TH_NEG) begin
            if (r_pend == SLIP_NONE) begin
               w_pend_nxt = SLIP_ADV;
               w_acc_nxt  = w_sum + TH_POS;
            end else begin
               w_acc_nxt  = CLAMP_NEG;
            end
         end
      end
   end

   always_comb begin
      w_len_load = CNT_W'(SPS);
      if (w_pend_nxt == SLIP_RET)
         w_len_load = CNT_W'(SPS + 1);
      else if (w_pend_nxt == SLIP_ADV)
         w_len_load = CNT_W'(SPS - 1);
   end

   assign sym_strobe_o = en_i && (r_state != ST_IDLE) && smp_valid_i && (r_cnt == r_len - 1'b1);
   assign slip_o       = sym_strobe_o ? w_pend_nxt : SLIP_NONE;

   mm_lock_det #(
      .LOCK_CNT (LOCK_CNT)
   ) u_lock_det (
      .clk          (clk),
      .reset        (reset),
      .i_clr        (!w_tracking),
      .i_good       (w_err_act && (w_mag < LOCK_M)),
      .i_miss       (w_err_act && !(w_mag < LOCK_M)),
      .i_bad        (w_err_act && (w_mag >= UNLOCK_M)),
      .o_locked_nxt (w_locked_nxt),
      .o_locked     (w_locked)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state    <= ST_IDLE;
         r_warm     <= '0;
         r_cnt      <= '0;
         r_len      <= CNT_W'(SPS);
         r_acc      <= '0;
         r_pend     <= SLIP_NONE;
         r_slip_cnt <= '0;
      end else if (!en_i) begin
         r_state    <= ST_IDLE;
         r_warm     <= '0;
         r_cnt      <= '0;
         r_len      <= CNT_W'(SPS);
         r_acc      <= '0;
         r_pend     <= SLIP_NONE;
         r_slip_cnt <= '0;
      end else begin
         case (r_state)
            ST_IDLE:    r_state <= ST_ACQUIRE;
            ST_ACQUIRE: begin
               if (ted_err_valid_i) begin
                  if (r_warm == WARM_W'(WARMUP - 1)) begin
                     r_state <= ST_TRACK;
                     r_warm  <= '0;
                  end else begin
                     r_warm  <= r_warm + 1'b1;
                  end
               end
            end
            ST_TRACK:   if (w_locked_nxt)  r_state <= ST_LOCKED;
            ST_LOCKED:  if (!w_locked_nxt) r_state <= ST_TRACK;
            default:    r_state <= ST_IDLE;
         endcase

         if (sym_strobe_o) begin
            r_cnt  <= '0;
            r_len  <= w_len_load;
            r_pend <= SLIP_NONE;
            if (w_pend_nxt != SLIP_NONE && r_slip_cnt != 16'hFFFF)
               r_slip_cnt <= r_slip_cnt + 1'b1;
         end else begin
            if (r_state != ST_IDLE && smp_valid_i)
               r_cnt <= r_cnt + 1'b1;
            r_pend <= w_pend_nxt;
         end
         r_acc <= w_acc_nxt;
      end
   end

   assign state_o    = r_state;
   assign locked_o   = w_locked;
   assign slip_cnt_o = r_slip_cnt;

endmodule
